// File: rtl/emif_amm_arbiter.sv
// Two-requester round-robin arbiter for the EMIF Avalon-MM user port, with write-burst
// locking and in-order read-response routing. Optional counters: EMIF_AMM_ARB_PERF_EN.
module emif_amm_arbiter #(
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 576,
  parameter int BURST_W   = 7,
  parameter int TAG_DEPTH = 32
) (
  input  logic                emif_usr_clk,
  input  logic                emif_usr_rst,
  input  logic                s0_read,
  input  logic                s0_write,
  input  logic [ADDR_W-1:0]   s0_address,
  input  logic [DATA_W-1:0]   s0_writedata,
  input  logic [DATA_W/8-1:0] s0_byteenable,
  input  logic [BURST_W-1:0]  s0_burstcount,
  output logic                s0_ready,
  output logic                s0_readdatavalid,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W-1:0]   s1_writedata,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [BURST_W-1:0]  s1_burstcount,
  output logic                s1_ready,
  output logic                s1_readdatavalid,
  output logic [DATA_W-1:0]   s_readdata,
  input  logic                m_ready,
  output logic                m_read,
  output logic                m_write,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [BURST_W-1:0]  m_burstcount,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic                err_orphan_rd
`ifdef EMIF_AMM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_rd_cnt0,
  output logic [31:0]         perf_rd_cnt1,
  output logic [31:0]         perf_wr_cnt0,
  output logic [31:0]         perf_wr_cnt1,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int AW = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE, WR_LOCK} state_t;

  state_t               state, state_nxt;
  logic                 rr_last;
  logic                 lock_port;
  logic [BURST_W-1:0]   beats_left;

  logic [BURST_W:0]     tag_mem [TAG_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          tag_cnt;
  logic [BURST_W-1:0]   beat_cnt;

  logic                 fifo_full, fifo_empty;
  logic                 elig0, elig1;
  logic                 sel, sel_ok;
  logic                 cmd_wr, cmd_rd;
  logic [BURST_W-1:0]   sel_bc, eff_bc;
  logic                 accept, push, pop, rdv_hit;
  logic                 head_port;
  logic [BURST_W-1:0]   head_bc;

  assign fifo_full  = (tag_cnt == (AW+1)'(TAG_DEPTH));
  assign fifo_empty = (tag_cnt == '0);

  assign elig0 = s0_write || (s0_read && !fifo_full);
  assign elig1 = s1_write || (s1_read && !fifo_full);

  // Arbitration and next-state; a write takes precedence if a requester raises both.
  always_comb begin
    state_nxt = state;
    sel       = 1'b0;
    sel_ok    = 1'b0;
    cmd_wr    = 1'b0;
    cmd_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 && elig1) sel = ~rr_last;
        else if (elig1)     sel = 1'b1;
        else                sel = 1'b0;
        sel_ok = elig0 || elig1;
        cmd_wr = sel ? s1_write : s0_write;
        cmd_rd = !cmd_wr && (sel ? s1_read : s0_read);
      end
      WR_LOCK: begin
        sel    = lock_port;
        cmd_wr = lock_port ? s1_write : s0_write;
        sel_ok = cmd_wr;
      end
      default: state_nxt = IDLE;
    endcase

    m_write = !emif_usr_rst && sel_ok && cmd_wr;
    m_read  = !emif_usr_rst && sel_ok && cmd_rd;
    accept  = (m_read || m_write) && m_ready;

    if (state == IDLE && accept && m_write && eff_bc > BURST_W'(1)) state_nxt = WR_LOCK;
    if (state == WR_LOCK && accept && beats_left == BURST_W'(1))    state_nxt = IDLE;
  end

  // A zero burstcount is illegal on Avalon; it is forwarded and tracked as a single beat.
  assign sel_bc = sel ? s1_burstcount : s0_burstcount;
  assign eff_bc = (sel_bc == '0) ? BURST_W'(1) : sel_bc;

  assign m_address    = sel ? s1_address    : s0_address;
  assign m_writedata  = sel ? s1_writedata  : s0_writedata;
  assign m_byteenable = sel ? s1_byteenable : s0_byteenable;
  assign m_burstcount = eff_bc;

  assign s0_ready = !emif_usr_rst && m_ready && sel_ok && !sel;
  assign s1_ready = !emif_usr_rst && m_ready && sel_ok &&  sel;

  assign head_port = tag_mem[rd_ptr][BURST_W];
  assign head_bc   = tag_mem[rd_ptr][BURST_W-1:0];

  assign push    = accept && m_read;
  assign rdv_hit = !emif_usr_rst && m_readdatavalid && !fifo_empty;
  assign pop     = rdv_hit && (BURST_W'(beat_cnt + 1'b1) == head_bc);

  assign s0_readdatavalid = rdv_hit && !head_port;
  assign s1_readdatavalid = rdv_hit &&  head_port;
  assign s_readdata       = m_readdata;

  always_ff @(posedge emif_usr_clk) begin
    if (emif_usr_rst) state <= IDLE;
    else              state <= state_nxt;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge emif_usr_clk) begin
    if (emif_usr_rst) begin
      rr_last       <= 1'b1;
      lock_port     <= 1'b0;
      beats_left    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tag_cnt       <= '0;
      beat_cnt      <= '0;
      err_orphan_rd <= 1'b0;
    end else begin
      if (accept && state == IDLE) begin
        rr_last <= sel;
        if (m_write && eff_bc > BURST_W'(1)) begin
          lock_port  <= sel;
          beats_left <= eff_bc - 1'b1;
        end
      end
      if (accept && state == WR_LOCK) beats_left <= beats_left - 1'b1;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase

      if (rdv_hit) beat_cnt <= pop ? '0 : beat_cnt + 1'b1;
      if (m_readdatavalid && fifo_empty) err_orphan_rd <= 1'b1;
    end
  end

  // NOTE: the tag storage has no reset; pointers and occupancy alone define which entries are live.
  always_ff @(posedge emif_usr_clk) begin
    if (push) tag_mem[wr_ptr] <= {sel, eff_bc};
  end

`ifdef EMIF_AMM_ARB_PERF_EN
  logic stall;
  assign stall = ((s0_read || s0_write) && !s0_ready) || ((s1_read || s1_write) && !s1_ready);

  always_ff @(posedge emif_usr_clk) begin
    if (emif_usr_rst) begin
      perf_rd_cnt0   <= '0;
      perf_rd_cnt1   <= '0;
      perf_wr_cnt0   <= '0;
      perf_wr_cnt1   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept && m_read  && !sel && perf_rd_cnt0 != '1) perf_rd_cnt0 <= perf_rd_cnt0 + 1'b1;
      if (accept && m_read  &&  sel && perf_rd_cnt1 != '1) perf_rd_cnt1 <= perf_rd_cnt1 + 1'b1;
      if (accept && m_write && !sel && perf_wr_cnt0 != '1) perf_wr_cnt0 <= perf_wr_cnt0 + 1'b1;
      if (accept && m_write &&  sel && perf_wr_cnt1 != '1) perf_wr_cnt1 <= perf_wr_cnt1 + 1'b1;
      if (stall && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_emif_amm_arbiter.sv
// Directed self-checking bench for emif_amm_arbiter (narrow data, 4-entry tag FIFO).
module tb_emif_amm_arbiter;

  localparam int ADDR_W = 27, DATA_W = 32, BURST_W = 7, TAG_DEPTH = 4;

  logic                emif_usr_clk = 1'b0;
  logic                emif_usr_rst;
  logic                s0_read, s0_write, s1_read, s1_write;
  logic [ADDR_W-1:0]   s0_address, s1_address;
  logic [DATA_W-1:0]   s0_writedata, s1_writedata;
  logic [DATA_W/8-1:0] s0_byteenable, s1_byteenable;
  logic [BURST_W-1:0]  s0_burstcount, s1_burstcount;
  logic                s0_ready, s1_ready, s0_readdatavalid, s1_readdatavalid;
  logic [DATA_W-1:0]   s_readdata;
  logic                m_ready, m_read, m_write;
  logic [ADDR_W-1:0]   m_address;
  logic [DATA_W-1:0]   m_writedata;
  logic [DATA_W/8-1:0] m_byteenable;
  logic [BURST_W-1:0]  m_burstcount;
  logic [DATA_W-1:0]   m_readdata;
  logic                m_readdatavalid;
  logic                err_orphan_rd;

  int errors = 0;
  int checks = 0;

  emif_amm_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .emif_usr_clk(emif_usr_clk), .emif_usr_rst(emif_usr_rst),
    .s0_read(s0_read), .s0_write(s0_write), .s0_address(s0_address),
    .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
    .s0_burstcount(s0_burstcount), .s0_ready(s0_ready),
    .s0_readdatavalid(s0_readdatavalid),
    .s1_read(s1_read), .s1_write(s1_write), .s1_address(s1_address),
    .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
    .s1_burstcount(s1_burstcount), .s1_ready(s1_ready),
    .s1_readdatavalid(s1_readdatavalid),
    .s_readdata(s_readdata), .m_ready(m_ready), .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_burstcount(m_burstcount), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .err_orphan_rd(err_orphan_rd)
  );

  always #5 emif_usr_clk = ~emif_usr_clk;

  // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
  task automatic tick();
    @(posedge emif_usr_clk);
    #1;
  endtask

  task automatic test_reset();
    emif_usr_rst = 1'b1;
    s0_read = 1'b1; s1_read = 1'b1; m_ready = 1'b1; m_readdatavalid = 1'b1;
    tick(); tick();
    #2;
    checks++;
    if ({s0_ready, s1_ready, m_read, m_write, s0_readdatavalid, s1_readdatavalid, err_orphan_rd} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {s0_ready, s1_ready, m_read, m_write, s0_readdatavalid, s1_readdatavalid, err_orphan_rd});
    end
    emif_usr_rst = 1'b0; s0_read = 1'b0; s1_read = 1'b0; m_readdatavalid = 1'b0;
    tick();
    #2;
    checks++;
    if (err_orphan_rd !== 1'b0) begin
      errors++; $display("FAIL reset_orphan: got %b want 0", err_orphan_rd);
    end
  endtask

  task automatic test_rr_reads();
    logic [3:0] exp_hs;
    s0_read = 1'b1; s1_read = 1'b1;
    s0_address = 27'h100; s1_address = 27'h200;
    s0_burstcount = 7'd1; s1_burstcount = 7'd1;
    for (int i = 0; i < 4; i++) begin
      #2;
      exp_hs = (i % 2 == 0) ? 4'b1010 : 4'b0110;
      checks++;
      if ({s0_ready, s1_ready, m_read, m_write} !== exp_hs ||
          m_address !== ((i % 2 == 0) ? 27'h100 : 27'h200)) begin
        errors++;
        $display("FAIL rr_grant%0d: got hs=%b addr=%h want hs=%b", i,
                 {s0_ready, s1_ready, m_read, m_write}, m_address, exp_hs);
      end
      tick();
    end
    s0_read = 1'b0; s1_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_readdatavalid = 1'b1; m_readdata = 32'hA000 + i;
      #2;
      checks++;
      if ({s0_readdatavalid, s1_readdatavalid} !== ((i % 2 == 0) ? 2'b10 : 2'b01) ||
          s_readdata !== 32'hA000 + i) begin
        errors++;
        $display("FAIL rr_return%0d: got rdv=%b data=%h want rdv=%b data=%h", i,
                 {s0_readdatavalid, s1_readdatavalid}, s_readdata,
                 (i % 2 == 0) ? 2'b10 : 2'b01, 32'hA000 + i);
      end
      tick();
    end
    m_readdatavalid = 1'b0;
  endtask

  task automatic test_burst_lock();
    s0_write = 1'b1; s0_burstcount = 7'd4; s0_address = 27'h40; s0_writedata = 32'hD000;
    s1_read = 1'b1; s1_address = 27'h300; s1_burstcount = 7'd1; m_ready = 1'b1;
    #2;
    checks++;
    if ({s0_ready, s1_ready, m_read, m_write} !== 4'b1001 || m_burstcount !== 7'd4 ||
        m_writedata !== 32'hD000) begin
      errors++;
      $display("FAIL burst_first: got hs=%b bc=%0d wd=%h want hs=1001 bc=4 wd=d000",
               {s0_ready, s1_ready, m_read, m_write}, m_burstcount, m_writedata);
    end
    tick();
    m_ready = 1'b0; s0_writedata = 32'hD001;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if ({s0_ready, s1_ready, m_read, m_write} !== 4'b0001 || m_address !== 27'h40) begin
        errors++;
        $display("FAIL burst_stall%0d: got hs=%b addr=%h want hs=0001 addr=40", i,
                 {s0_ready, s1_ready, m_read, m_write}, m_address);
      end
      tick();
    end
    m_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      s0_writedata = 32'hD000 + k;
      #2;
      checks++;
      if ({s0_ready, s1_ready, m_read, m_write} !== 4'b1001 || m_writedata !== 32'hD000 + k) begin
        errors++;
        $display("FAIL burst_beat%0d: got hs=%b wd=%h want hs=1001 wd=%h", k,
                 {s0_ready, s1_ready, m_read, m_write}, m_writedata, 32'hD000 + k);
      end
      tick();
    end
    s0_write = 1'b0;
    #2;
    checks++;
    if ({s0_ready, s1_ready, m_read, m_write} !== 4'b0110 || m_address !== 27'h300) begin
      errors++;
      $display("FAIL burst_release: got hs=%b addr=%h want hs=0110 addr=300",
               {s0_ready, s1_ready, m_read, m_write}, m_address);
    end
    tick();
    s1_read = 1'b0; m_readdatavalid = 1'b1; m_readdata = 32'hB000;
    #2;
    checks++;
    if ({s0_readdatavalid, s1_readdatavalid} !== 2'b01 || s_readdata !== 32'hB000) begin
      errors++;
      $display("FAIL burst_rd_return: got rdv=%b data=%h want rdv=01 data=b000",
               {s0_readdatavalid, s1_readdatavalid}, s_readdata);
    end
    tick();
    m_readdatavalid = 1'b0;
  endtask

  task automatic test_fifo_full();
    s1_read = 1'b1; s1_address = 27'h400; s1_burstcount = 7'd1;
    for (int i = 0; i < TAG_DEPTH; i++) begin
      #2;
      checks++;
      if ({s0_ready, s1_ready, m_read, m_write} !== 4'b0110) begin
        errors++;
        $display("FAIL fill%0d: got hs=%b want 0110", i, {s0_ready, s1_ready, m_read, m_write});
      end
      tick();
    end
    #2;
    checks++;
    if ({s0_ready, s1_ready, m_read, m_write} !== 4'b0000) begin
      errors++;
      $display("FAIL full_stall: got hs=%b want 0000", {s0_ready, s1_ready, m_read, m_write});
    end
    s0_write = 1'b1; s0_burstcount = 7'd1; s0_address = 27'h50;
    #2;
    checks++;
    if ({s0_ready, s1_ready, m_read, m_write} !== 4'b1001 || m_address !== 27'h50) begin
      errors++;
      $display("FAIL full_write: got hs=%b addr=%h want hs=1001 addr=50",
               {s0_ready, s1_ready, m_read, m_write}, m_address);
    end
    tick();
    s0_write = 1'b0; m_readdatavalid = 1'b1; m_readdata = 32'hC000;
    #2;
    checks++;
    if ({s0_ready, s1_ready, m_read, m_write, s0_readdatavalid, s1_readdatavalid} !== 6'b000001) begin
      errors++;
      $display("FAIL full_pop_cycle: got %b want 000001",
               {s0_ready, s1_ready, m_read, m_write, s0_readdatavalid, s1_readdatavalid});
    end
    tick();
    m_readdatavalid = 1'b0;
    #2;
    checks++;
    if ({s0_ready, s1_ready, m_read, m_write} !== 4'b0110) begin
      errors++;
      $display("FAIL full_readmit: got hs=%b want 0110", {s0_ready, s1_ready, m_read, m_write});
    end
    tick();
    s1_read = 1'b0;
    for (int i = 1; i <= TAG_DEPTH; i++) begin
      m_readdatavalid = 1'b1; m_readdata = 32'hC000 + i;
      #2;
      checks++;
      if ({s0_readdatavalid, s1_readdatavalid} !== 2'b01) begin
        errors++;
        $display("FAIL full_drain%0d: got rdv=%b want 01", i, {s0_readdatavalid, s1_readdatavalid});
      end
      tick();
    end
    m_readdatavalid = 1'b0;
  endtask

  task automatic test_interleave();
    logic [1:0] exp_rdv;
    s0_read = 1'b1; s0_burstcount = 7'd2; s0_address = 27'h10;
    s1_read = 1'b1; s1_burstcount = 7'd1; s1_address = 27'h20;
    #2;
    checks++;
    if ({s0_ready, s1_ready, m_read, m_write} !== 4'b1010 || m_burstcount !== 7'd2) begin
      errors++;
      $display("FAIL il_grant0: got hs=%b bc=%0d want hs=1010 bc=2",
               {s0_ready, s1_ready, m_read, m_write}, m_burstcount);
    end
    tick();
    s0_read = 1'b0;
    #2;
    checks++;
    if ({s0_ready, s1_ready, m_read, m_write} !== 4'b0110 || m_burstcount !== 7'd1) begin
      errors++;
      $display("FAIL il_grant1: got hs=%b bc=%0d want hs=0110 bc=1",
               {s0_ready, s1_ready, m_read, m_write}, m_burstcount);
    end
    tick();
    s1_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_rdv = (i < 2) ? 2'b10 : 2'b01;
      m_readdatavalid = 1'b1; m_readdata = 32'hE000 + i;
      #2;
      checks++;
      if ({s0_readdatavalid, s1_readdatavalid} !== exp_rdv) begin
        errors++;
        $display("FAIL il_return%0d: got rdv=%b want %b", i,
                 {s0_readdatavalid, s1_readdatavalid}, exp_rdv);
      end
      tick();
    end
    m_readdatavalid = 1'b0;
    #2;
    checks++;
    if (err_orphan_rd !== 1'b0) begin
      errors++; $display("FAIL il_no_orphan: got %b want 0", err_orphan_rd);
    end
  endtask

  task automatic test_orphan();
    m_readdatavalid = 1'b1; m_readdata = 32'hF00D;
    #2;
    checks++;
    if ({s0_readdatavalid, s1_readdatavalid} !== 2'b00) begin
      errors++;
      $display("FAIL orphan_drop: got rdv=%b want 00", {s0_readdatavalid, s1_readdatavalid});
    end
    tick();
    m_readdatavalid = 1'b0;
    tick();
    #2;
    checks++;
    if (err_orphan_rd !== 1'b1) begin
      errors++; $display("FAIL orphan_sticky: got %b want 1", err_orphan_rd);
    end
  endtask

  task automatic test_reset_mid_burst();
    s0_write = 1'b1; s0_burstcount = 7'd1; s0_address = 27'h60;
    #2;
    checks++;
    if ({s0_ready, s1_ready, m_read, m_write} !== 4'b1001) begin
      errors++;
      $display("FAIL mid_single: got hs=%b want 1001", {s0_ready, s1_ready, m_read, m_write});
    end
    tick();
    s0_burstcount = 7'd4;
    #2;
    checks++;
    if ({s0_ready, s1_ready, m_read, m_write} !== 4'b1001) begin
      errors++;
      $display("FAIL mid_burst_start: got hs=%b want 1001", {s0_ready, s1_ready, m_read, m_write});
    end
    tick();
    emif_usr_rst = 1'b1;
    #2;
    checks++;
    if ({s0_ready, s1_ready, m_read, m_write} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_in_reset: got hs=%b want 0000", {s0_ready, s1_ready, m_read, m_write});
    end
    tick();
    emif_usr_rst = 1'b0; s0_write = 1'b0;
    s0_read = 1'b1; s0_burstcount = 7'd1; s0_address = 27'h70;
    s1_read = 1'b1; s1_burstcount = 7'd1; s1_address = 27'h80;
    #2;
    checks++;
    if (err_orphan_rd !== 1'b0 || {s0_ready, s1_ready, m_read, m_write} !== 4'b1010 ||
        m_address !== 27'h70) begin
      errors++;
      $display("FAIL mid_after_reset: got err=%b hs=%b addr=%h want err=0 hs=1010 addr=70",
               err_orphan_rd, {s0_ready, s1_ready, m_read, m_write}, m_address);
    end
    tick();
    s0_read = 1'b0; s1_read = 1'b0;
  endtask

  initial begin
    emif_usr_rst = 1'b1;
    s0_read = 1'b0; s0_write = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s0_address = '0; s1_address = '0; s0_writedata = '0; s1_writedata = '0;
    s0_byteenable = '1; s1_byteenable = '1; s0_burstcount = 7'd1; s1_burstcount = 7'd1;
    m_ready = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;

    test_reset();
    test_rr_reads();
    test_burst_lock();
    test_fifo_full();
    test_interleave();
    test_orphan();
    test_reset_mid_burst();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
